// File: rtl/adc_serial_multi.sv
// Multi-channel serial ADC reader: shared cs/sclk, one sdata line per channel, offset-binary to signed words.
// Latency: cs low for (2*FRAME+1)*CLK_DIV cycles, sample_valid one cycle after cs rises; optional ADC_AVG_EN averages 4 frames.
// No backpressure: sample_valid is a one-cycle strobe, dato_final holds until the next strobe.
module adc_serial_multi #(
    parameter int NUM_CH     = 2,
    parameter int ADC_BITS   = 12,
    parameter int LEAD_BITS  = 4,
    parameter int OUT_W      = 25,
    parameter int FRAC_SHIFT = 0,
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_PER = 100,
    parameter int QUIET_CYC  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         sdata,
    output logic                      cs,
    output logic                      sclk,
    output logic                      busy,
    output logic                      sample_valid,
    output logic [NUM_CH*OUT_W-1:0]   dato_final
);

    localparam int FRAME = LEAD_BITS + ADC_BITS;
    localparam int HW    = $clog2(CLK_DIV + 1);
    localparam int EW    = $clog2(FRAME + 1);
    localparam int QW    = $clog2(QUIET_CYC + 2);
    localparam int PW    = $clog2(SAMPLE_PER + 1);

    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [EW-1:0] E_LAST = EW'(FRAME);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);
    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PER - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_QUIET = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]          state;
    logic [HW-1:0]       hcnt;
    logic [EW-1:0]       ecnt;
    logic [QW-1:0]       qcnt;
    logic [PW-1:0]       pcnt;
    logic                en_lost;
    logic                latch_pend;
    logic [ADC_BITS-1:0] shreg [NUM_CH];

    // Offset binary to two's complement is just an MSB flip.
    function automatic logic signed [ADC_BITS-1:0] sval(input logic [ADC_BITS-1:0] code);
        return {~code[ADC_BITS-1], code[ADC_BITS-2:0]};
    endfunction

    function automatic logic signed [OUT_W-1:0] fmt(input logic signed [ADC_BITS+1:0] v);
        return OUT_W'(v) <<< FRAC_SHIFT;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cs         <= 1'b1;
            sclk       <= 1'b1;
            busy       <= 1'b0;
            hcnt       <= '0;
            ecnt       <= '0;
            qcnt       <= '0;
            pcnt       <= '0;
            en_lost    <= 1'b0;
            latch_pend <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) shreg[k] <= '0;
        end else begin
            latch_pend <= 1'b0;
            if (pcnt != P_LAST) pcnt <= pcnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state   <= S_SHIFT;
                        cs      <= 1'b0;
                        busy    <= 1'b1;
                        pcnt    <= '0;
                        hcnt    <= '0;
                        ecnt    <= '0;
                        en_lost <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (!en) en_lost <= 1'b1;
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        // One extra half-period after the last rising edge, then release cs.
                        if (ecnt == E_LAST) begin
                            cs         <= 1'b1;
                            busy       <= 1'b0;
                            latch_pend <= 1'b1;
                            qcnt       <= '0;
                            state      <= S_QUIET;
                        end else begin
                            sclk <= ~sclk;
                            if (!sclk) begin
                                ecnt <= ecnt + 1'b1;
                                for (int k = 0; k < NUM_CH; k++)
                                    shreg[k] <= {shreg[k][ADC_BITS-2:0], sdata[k]};
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_QUIET: begin
                    if (qcnt == Q_LAST) state <= (en_lost || !en) ? S_IDLE : S_WAIT;
                    else qcnt <= qcnt + 1'b1;
                end
                S_WAIT: begin
                    if (pcnt == P_LAST) begin
                        if (en) begin
                            state   <= S_SHIFT;
                            cs      <= 1'b0;
                            busy    <= 1'b1;
                            pcnt    <= '0;
                            hcnt    <= '0;
                            ecnt    <= '0;
                            en_lost <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_AVG_EN
    logic signed [ADC_BITS+1:0] acc [NUM_CH];
    logic signed [ADC_BITS+1:0] sum [NUM_CH];
    logic [1:0]                 fcnt;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            sum[k] = acc[k] + (ADC_BITS+2)'(sval(shreg[k]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_valid <= 1'b0;
            dato_final   <= '0;
            fcnt         <= '0;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (latch_pend) begin
                if (fcnt == 2'd3) begin
                    sample_valid <= 1'b1;
                    fcnt         <= '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        dato_final[k*OUT_W +: OUT_W] <= fmt(sum[k] >>> 2);
                        acc[k] <= '0;
                    end
                end else begin
                    fcnt <= fcnt + 1'b1;
                    for (int k = 0; k < NUM_CH; k++) acc[k] <= sum[k];
                end
            end
            if (state == S_IDLE) begin
                fcnt <= '0;
                for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_valid <= 1'b0;
            dato_final   <= '0;
        end else begin
            sample_valid <= latch_pend;
            if (latch_pend) begin
                for (int k = 0; k < NUM_CH; k++)
                    dato_final[k*OUT_W +: OUT_W] <= fmt((ADC_BITS+2)'(sval(shreg[k])));
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_serial_multi.sv
// Bench for adc_serial_multi: default instance plus a single-channel FRAC_SHIFT=4 instance sharing stimulus.
// A behavioural ADC drives sdata on sclk falling edges; expected words are queued per frame and checked on sample_valid.
module tb_adc_serial_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  sdata;
    logic        cs, sclk, busy, sample_valid;
    logic [49:0] dato_final;
    logic        cs_f, sclk_f, busy_f, valid_f;
    logic [24:0] dato_f;

    always #5 clk = ~clk;

    adc_serial_multi u_dut (
        .clk(clk), .rst(rst), .en(en), .sdata(sdata),
        .cs(cs), .sclk(sclk), .busy(busy),
        .sample_valid(sample_valid), .dato_final(dato_final)
    );

    adc_serial_multi #(.NUM_CH(1), .FRAC_SHIFT(4)) u_frac (
        .clk(clk), .rst(rst), .en(en), .sdata(sdata[0]),
        .cs(cs_f), .sclk(sclk_f), .busy(busy_f),
        .sample_valid(valid_f), .dato_final(dato_f)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int nvalid = 0;

    logic [49:0] q_main [$];
    logic [24:0] q_frac [$];
    logic [15:0] fw0 = 16'h0, fw1 = 16'h0;
    logic [15:0] cur0 = 16'h0, cur1 = 16'h0;
    int          bitn = 0;
    int          acc0 = 0, acc1 = 0, nfr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // ADC model: latch the 16-bit frame on cs fall, present one bit per sclk falling edge.
    always @(negedge cs or negedge sclk) begin
        if (sclk) begin
            cur0 = fw0;
            cur1 = fw1;
            bitn = 0;
        end else if (!cs && bitn < 16) begin
            sdata = {cur1[15-bitn], cur0[15-bitn]};
            bitn++;
        end
    end

    always @(negedge clk) begin
        logic [49:0] em;
        logic [24:0] ef;
        if (sample_valid) begin
            nvalid++;
            if (q_main.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                em = q_main.pop_front();
                check("dato_main", dato_final, em);
            end
        end
        if (valid_f) begin
            if (q_frac.size() == 0) check("unexpected_valid_frac", 1, 0);
            else begin
                ef = q_frac.pop_front();
                check("dato_frac", dato_f, ef);
            end
        end
    end

    task automatic push_exp(input logic [15:0] w0, input logic [15:0] w1);
        int s0, s1;
        s0 = int'(w0[11:0]) - 2048;
        s1 = int'(w1[11:0]) - 2048;
`ifdef ADC_AVG_EN
        acc0 += s0;
        acc1 += s1;
        nfr++;
        if (nfr == 4) begin
            s0 = acc0 >>> 2;
            s1 = acc1 >>> 2;
            q_main.push_back({25'(s1), 25'(s0)});
            q_frac.push_back(25'(s0 * 16));
            acc0 = 0; acc1 = 0; nfr = 0;
        end
`else
        q_main.push_back({25'(s1), 25'(s0)});
        q_frac.push_back(25'(s0 * 16));
`endif
    endtask

    task automatic set_frame(input logic [15:0] w0, input logic [15:0] w1);
        fw0 = w0;
        fw1 = w1;
        push_exp(w0, w1);
    endtask

    task automatic wait_cs(input logic lvl, input int budget, input string tag);
        int i = 0;
        while (cs !== lvl && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, cs, lvl);
    endtask

    // Waits for the frame already configured to start, then configures the one after it.
    task automatic start_next(input logic [15:0] w0, input logic [15:0] w1);
        wait_cs(1'b1, 200, "cs_high_wait");
        wait_cs(1'b0, 200, "cs_low_wait");
        set_frame(w0, w1);
    endtask

    initial begin
        int t0, i, nv0, nlow;
        rst = 1'b0;
        en = 1'b0;
        sdata = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_dato", dato_final, 0);
        check("rst_dato_frac", dato_f, 0);

        rst = 1'b1;
        @(negedge clk);
        set_frame(16'h0800, 16'h0800);
        en = 1'b1;
        wait_cs(1'b0, 10, "first_cs_fall");
        t0 = cyc;
        check("busy_low_cs", busy, 1);
        set_frame(16'h0FFF, 16'h0000);
        i = 0;
        while (sclk && i < 10) begin @(negedge clk); i++; end
        check("sclk_fall_cyc", cyc - t0, 2);
        wait_cs(1'b1, 200, "first_cs_rise");
        check("cs_low_len", cyc - t0, 66);
        check("busy_after", busy, 0);
`ifndef ADC_AVG_EN
        i = 0;
        while (!sample_valid && i < 10) begin @(negedge clk); i++; end
        check("valid_cyc", cyc - t0, 67);
`endif

        start_next(16'hF801, 16'h0123);
        start_next(16'hF800, 16'hF800);
        start_next(16'($urandom), 16'($urandom));
        start_next(16'($urandom), 16'($urandom));
        start_next(16'($urandom), 16'($urandom));
        t0 = cyc;
        start_next(16'($urandom), 16'($urandom));
        check("frame_period", cyc - t0, 100);

        // Drop en 20 cycles into the last frame.
        wait_cs(1'b1, 200, "drop_pre_high");
        wait_cs(1'b0, 200, "drop_frame_start");
        nv0 = nvalid;
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_cs(1'b1, 200, "drop_frame_end");
        nlow = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (!cs) nlow++;
        end
        check("no_frame_after_drop", nlow, 0);
        check("one_valid_after_drop", nvalid - nv0, 1);
        check("queue_drained", q_main.size() + q_frac.size(), 0);

        // Reset 30 cycles into a frame whose result must never appear.
        acc0 = 0; acc1 = 0; nfr = 0;
        fw0 = 16'h0ABC;
        fw1 = 16'h0555;
        en = 1'b1;
        wait_cs(1'b0, 20, "rst_frame_start");
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_cs", cs, 1);
        check("midrst_sclk", sclk, 1);
        check("midrst_busy", busy, 0);
        check("midrst_cs_frac", cs_f, 1);
        nv0 = nvalid;
        repeat (5) @(negedge clk);
        check("midrst_no_valid", nvalid - nv0, 0);
        set_frame(16'h0FA5, 16'h0010);
        rst = 1'b1;
        i = 0;
        while ((q_main.size() != 0 || q_frac.size() != 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("post_rst_drained", q_main.size() + q_frac.size(), 0);
        en = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
